npu_inst_sched: RTL

- Instruction sequencer for the NPU core.
- Fetches 128-bit instructions from instruction RAM and presents each one to the decoder with a one-cycle valid.
- Launches DMA, conv/pool (N2IOB) and sorter (SOFTMAX) execution, then waits for their done handshakes.
- Handles JUMP, STOP, blocking and non-blocking DMA, and illegal opcodes.

---
 rtl/npu_pkg.sv | 44 ++++
 rtl/npu_inst_sched.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/npu_pkg.sv
// Shared definitions for the NPU instruction sequencer.
// Holds the opcode values, the bit positions of the instruction fields the
// sequencer reads, the sequencer state encoding and a legal-opcode helper.
package npu_pkg;

  localparam int INST_W = 128;

  // Instruction field positions
  localparam int OPC_HI       = 127;
  localparam int OPC_LO       = 123;
  localparam int JPC_HI       = 122;
  localparam int JPC_LO       = 111;
  localparam int JPC_W        = JPC_HI - JPC_LO + 1;
  localparam int NOBLOCK_BIT  = 20;   // DMA only: do not wait for completion
  localparam int WAIT_DMA_BIT = 37;   // any opcode: wait for last non-blocking DMA

  typedef enum logic [4:0] {
    OP_DMA     = 5'b10010,
    OP_IOB2N   = 5'b01010,
    OP_WB2N    = 5'b01011,
    OP_N2IOB   = 5'b01101,
    OP_SOFTMAX = 5'b00110,
    OP_STOP    = 5'b11111,
    OP_JUMP    = 5'b11100
  } opcode_t;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_FETCH,
    ST_RDWAIT,
    ST_CHECK,
    ST_ISSUE,
    ST_LAUNCH,
    ST_WAIT_EXEC,
    ST_DRAIN,
    ST_DONE,
    ST_ERR
  } state_t;

  function automatic logic opc_legal(input logic [4:0] op);
    return op inside {OP_DMA, OP_IOB2N, OP_WB2N, OP_N2IOB, OP_SOFTMAX, OP_STOP, OP_JUMP};
  endfunction

endpackage

// File: rtl/npu_inst_sched.sv
// NPU instruction sequencer.
// Fetches 128-bit instructions from a synchronous instruction RAM, presents
// each legal one to the decoder with a one-cycle strobe, launches DMA /
// compute / sorter work and waits for the matching done pulse.
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_start, i_start_pc     run request and first instruction address
//   o_ir_en, o_ir_addr      instruction RAM read port
//   i_ir_data               RAM read data, RD_LAT cycles after o_ir_en
//   o_inst, o_inst_valid    held instruction and decode strobe
//   o_dec_clr               decoder clear on an accepted start
//   o_*_start / i_*_done    launch pulses and completion pulses per unit
//   o_busy, o_done, o_err   status (o_err is sticky until the next start)
//   o_pc                    address of the instruction currently held
module npu_inst_sched
  import npu_pkg::*;
#(
  parameter int INST_AW = 12,
  parameter int RD_LAT  = 1
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_start,
  input  logic [INST_AW-1:0] i_start_pc,
  output logic               o_ir_en,
  output logic [INST_AW-1:0] o_ir_addr,
  input  logic [INST_W-1:0]  i_ir_data,
  output logic [INST_W-1:0]  o_inst,
  output logic               o_inst_valid,
  output logic               o_dec_clr,
  output logic               o_dma_start,
  input  logic               i_dma_done,
  output logic               o_calc_start,
  input  logic               i_calc_done,
  output logic               o_sort_start,
  input  logic               i_sort_done,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_err,
  output logic [INST_AW-1:0] o_pc
);

  localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  state_t             state_reg, state_next;
  logic [INST_AW-1:0] pc_reg, pc_next;
  logic [CNT_W-1:0]   rd_cnt_reg, rd_cnt_next;
  logic [INST_W-1:0]  inst_reg;
  logic               dma_out_reg, dma_out_next;
  logic               err_reg, err_next;
  logic               dec_clr_reg, dec_clr_next;
  logic               inst_load;
  logic               dma_set;
  logic               exec_done;

  logic [4:0]         opc;
  logic [JPC_W-1:0]   jump_pc;
  logic               noblock;
  logic               wait_dma;
  logic               is_dma;
  logic               rd_last;
  logic [INST_AW-1:0] pc_inc;

  assign opc     = inst_reg[OPC_HI:OPC_LO];
  assign jump_pc = inst_reg[JPC_HI:JPC_LO];
  assign noblock = inst_reg[NOBLOCK_BIT];
  assign wait_dma = inst_reg[WAIT_DMA_BIT];
  assign is_dma  = (opc == OP_DMA);
  assign rd_last = (rd_cnt_reg == CNT_W'(RD_LAT - 1));
  assign pc_inc  = pc_reg + INST_AW'(1);

  // Only the unit that was launched can end the wait
  always_comb begin
    exec_done = 1'b0;
    case (opc)
      OP_DMA:     exec_done = i_dma_done;
      OP_N2IOB:   exec_done = i_calc_done;
      OP_SOFTMAX: exec_done = i_sort_done;
      default:    exec_done = 1'b0;
    endcase
  end

  always_comb begin
    state_next   = state_reg;
    pc_next      = pc_reg;
    rd_cnt_next  = rd_cnt_reg;
    err_next     = err_reg;
    dec_clr_next = 1'b0;
    inst_load    = 1'b0;
    dma_set      = 1'b0;
    unique case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (i_start) begin
          pc_next      = i_start_pc;
          err_next     = 1'b0;
          dec_clr_next = 1'b1;
          state_next   = ST_FETCH;
        end
      end
      ST_FETCH: begin
        rd_cnt_next = '0;
        state_next  = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        if (rd_last) begin
          inst_load  = 1'b1;
          state_next = ST_CHECK;
        end else begin
          rd_cnt_next = rd_cnt_reg + CNT_W'(1);
        end
      end
      ST_CHECK: begin
        if (!opc_legal(opc)) begin
          err_next   = 1'b1;
          state_next = ST_ERR;
        end else if (!((wait_dma || is_dma) && dma_out_reg)) begin
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        case (opc)
          OP_IOB2N, OP_WB2N: begin
            pc_next    = pc_inc;
            state_next = ST_FETCH;
          end
          OP_JUMP: begin
            pc_next    = INST_AW'(jump_pc);
            state_next = ST_FETCH;
          end
          OP_STOP: state_next = ST_DRAIN;
          default: state_next = ST_LAUNCH;
        endcase
      end
      // One cycle after the strobe so the decoder's registered fields are stable
      ST_LAUNCH: begin
        if (is_dma && noblock) begin
          dma_set    = 1'b1;
          pc_next    = pc_inc;
          state_next = ST_FETCH;
        end else begin
          state_next = ST_WAIT_EXEC;
        end
      end
      ST_WAIT_EXEC: begin
        if (exec_done) begin
          pc_next    = pc_inc;
          state_next = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (!dma_out_reg) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // A new non-blocking launch takes priority over a coincident completion
  assign dma_out_next = dma_set | (dma_out_reg & ~i_dma_done);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_reg   <= ST_IDLE;
      pc_reg      <= '0;
      rd_cnt_reg  <= '0;
      inst_reg    <= '0;
      dma_out_reg <= 1'b0;
      err_reg     <= 1'b0;
      dec_clr_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      pc_reg      <= pc_next;
      rd_cnt_reg  <= rd_cnt_next;
      dma_out_reg <= dma_out_next;
      err_reg     <= err_next;
      dec_clr_reg <= dec_clr_next;
      if (inst_load) inst_reg <= i_ir_data;
    end
  end

  assign o_ir_en      = (state_reg == ST_FETCH);
  assign o_ir_addr    = pc_reg;
  assign o_inst       = inst_reg;
  assign o_inst_valid = (state_reg == ST_ISSUE);
  assign o_dec_clr    = dec_clr_reg;
  assign o_dma_start  = (state_reg == ST_LAUNCH) && is_dma;
  assign o_calc_start = (state_reg == ST_LAUNCH) && (opc == OP_N2IOB);
  assign o_sort_start = (state_reg == ST_LAUNCH) && (opc == OP_SOFTMAX);
  assign o_busy       = !(state_reg inside {ST_IDLE, ST_DONE, ST_ERR});
  assign o_done       = (state_reg == ST_DRAIN) && !dma_out_reg;
  assign o_err        = err_reg;
  assign o_pc         = pc_reg;

endmodule
